// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory controller.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Clocked storage with per-byte write enables and a registered read port.
// Deliberately reset-free so it can map onto block RAM.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [bytes_of(DATA_W)-1:0]   be,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata
);

    localparam int NB = bytes_of(DATA_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_sync_ctrl.sv
// Synchronous data memory: post-reset clear sequencer, valid/ready request port,
// fixed-latency read response (1 or 2 cycles).
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_CLEAR | zero-fill one word per cycle from address 0; requests stalled
//   ST_RUN   | normal operation, req_ready = init_done = 1 until reset
module dmem_sync_ctrl
    import dmem_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 8,
    parameter int                 RD_LAT    = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_done
);

    localparam int NB = bytes_of(DATA_W);
    localparam bit LAT2 = (RD_LAT >= RD_LAT_MAX);
    // Counter is one bit wider than the address so the terminal value never aliases.
    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    dmem_state_t state_q, state_d;
    logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
    logic ready_q, done_q;

    logic              accept;
    logic              arr_we, arr_re;
    logic [NB-1:0]     arr_be;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    logic              rd_v1_q, rd_v2_q;
    logic              data_ok_q;
    logic [DATA_W-1:0] rdata2_q;

    assign accept = req_valid & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_be    = '0;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        case (state_q)
            ST_CLEAR: begin
                arr_we    = 1'b1;
                arr_be    = '1;
                arr_addr  = clr_cnt_q[ADDR_W-1:0];
                arr_wdata = CLEAR_VAL;
                clr_cnt_d = clr_cnt_q + CLR_ONE;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                arr_we = accept & req_we;
                arr_re = accept & ~req_we;
                arr_be = req_be;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // data_ok masks the reset-free array register so rsp_rdata reads 0 after reset
    // until a fresh read has landed there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q   <= 1'b0;
            rd_v2_q   <= 1'b0;
            data_ok_q <= 1'b0;
            rdata2_q  <= '0;
        end else begin
            rd_v1_q   <= arr_re;
            rd_v2_q   <= rd_v1_q;
            data_ok_q <= data_ok_q | arr_re;
            if (rd_v1_q) begin
                rdata2_q <= arr_rdata;
            end
        end
    end

    assign rsp_valid = LAT2 ? rd_v2_q : rd_v1_q;
    assign rsp_rdata = LAT2 ? rdata2_q : (data_ok_q ? arr_rdata : '0);
    assign req_ready = ready_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_dmem_sync_ctrl.sv
// Directed bench: an 8-bit RD_LAT=1 instance and a 32-bit RD_LAT=2 instance.
module tb_dmem_sync_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v8 = 0, we8 = 0, rdy8, rv8, done8;
    logic [0:0]  be8 = '0;
    logic [7:0]  a8 = '0, wd8 = '0, rd8;

    logic        v32 = 0, we32 = 0, rdy32, rv32, done32;
    logic [3:0]  be32 = '0;
    logic [7:0]  a32 = '0;
    logic [31:0] wd32 = '0, rd32;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_sync_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .CLEAR_VAL(8'h00)) u8 (
        .clk(clk), .rst_n(rst_n), .req_valid(v8), .req_ready(rdy8), .req_we(we8),
        .req_be(be8), .req_addr(a8), .req_wdata(wd8), .rsp_valid(rv8),
        .rsp_rdata(rd8), .init_done(done8));

    dmem_sync_ctrl #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2), .CLEAR_VAL(32'h0)) u32 (
        .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32), .req_we(we32),
        .req_be(be32), .req_addr(a32), .req_wdata(wd32), .rsp_valid(rv32),
        .rsp_rdata(rd32), .init_done(done32));

    // Drive one request for one cycle; returns at the negedge after the accept edge.
    task automatic issue8(input logic we, input logic [7:0] addr, input logic [7:0] data);
        v8 = 1'b1; we8 = we; a8 = addr; wd8 = data; be8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic issue32(input logic we, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        v32 = 1'b1; we32 = we; a32 = addr; wd32 = data; be32 = be;
        @(negedge clk);
        v32 = 1'b0;
    endtask

    // Called on the release negedge; counts cycles with req_ready low (bounded).
    task automatic clear_wait(output int cnt, output int spurious);
        cnt = 0;
        spurious = 0;
        while (rdy8 !== 1'b1 && cnt < 400) begin
            if (rv8 === 1'b1 || rv32 === 1'b1) spurious++;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({rdy8, rv8, rd8, done8} !== 11'h0)
            $display("FAIL reset8: ready=%b valid=%b rdata=%h done=%b, want all 0", rdy8, rv8, rd8, done8);
        else passed++;
        total++;
        if ({rdy32, rv32, rd32, done32} !== 35'h0)
            $display("FAIL reset32: ready=%b valid=%b rdata=%h done=%b, want all 0", rdy32, rv32, rd32, done32);
        else passed++;
    endtask

    task automatic test_clear();
        int cnt, sp;
        rst_n = 1'b1;
        clear_wait(cnt, sp);
        total++;
        if (cnt != 256) $display("FAIL clear_len: %0d stalled cycles, want 256", cnt);
        else passed++;
        total++;
        if (sp != 0 || done8 !== 1'b1 || rdy32 !== 1'b1 || done32 !== 1'b1)
            $display("FAIL clear_done: spurious=%0d done8=%b rdy32=%b done32=%b, want 0/1/1/1", sp, done8, rdy32, done32);
        else passed++;
        issue8(1'b0, 8'd0, 8'h0);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'h00) $display("FAIL clear_rd0: valid=%b rdata=%h, want 1/00", rv8, rd8);
        else passed++;
        issue8(1'b0, 8'd127, 8'h0);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'h00) $display("FAIL clear_rd127: valid=%b rdata=%h, want 1/00", rv8, rd8);
        else passed++;
        issue8(1'b0, 8'd255, 8'h0);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'h00) $display("FAIL clear_rd255: valid=%b rdata=%h, want 1/00", rv8, rd8);
        else passed++;
    endtask

    task automatic test_write_read();
        issue8(1'b1, 8'h10, 8'hA5);
        issue8(1'b0, 8'h10, 8'h00);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'hA5) $display("FAIL wr_rd8: valid=%b rdata=%h, want 1/a5", rv8, rd8);
        else passed++;
        @(negedge clk);
        total++;
        if (rv8 !== 1'b0 || rd8 !== 8'hA5) $display("FAIL rd8_pulse_hold: valid=%b rdata=%h, want 0/a5", rv8, rd8);
        else passed++;
        issue32(1'b1, 8'h10, 32'h0000_00A5, 4'b0001);
        issue32(1'b0, 8'h10, 32'h0, 4'b0000);
        total++;
        if (rv32 !== 1'b0) $display("FAIL lat2_early: valid=%b, want 0", rv32);
        else passed++;
        @(negedge clk);
        total++;
        if (rv32 !== 1'b1 || rd32 !== 32'h0000_00A5) $display("FAIL wr_rd32: valid=%b rdata=%h, want 1/000000a5", rv32, rd32);
        else passed++;
        @(negedge clk);
        total++;
        if (rv32 !== 1'b0 || rd32 !== 32'h0000_00A5) $display("FAIL rd32_pulse_hold: valid=%b rdata=%h, want 0/000000a5", rv32, rd32);
        else passed++;
    endtask

    task automatic test_byte_lanes();
        issue32(1'b1, 8'd4, 32'h1122_3344, 4'b1111);
        issue32(1'b1, 8'd4, 32'hFFFF_FFFF, 4'b0101);
        issue32(1'b0, 8'd4, 32'h0, 4'b0000);
        @(negedge clk);
        total++;
        if (rv32 !== 1'b1 || rd32 !== 32'h11FF_33FF) $display("FAIL byte_lanes: valid=%b rdata=%h, want 1/11ff33ff", rv32, rd32);
        else passed++;
        issue32(1'b1, 8'd4, 32'hDEAD_BEEF, 4'b0000);
        issue32(1'b0, 8'd4, 32'h0, 4'b0000);
        @(negedge clk);
        total++;
        if (rv32 !== 1'b1 || rd32 !== 32'h11FF_33FF) $display("FAIL be_zero_noop: valid=%b rdata=%h, want 1/11ff33ff", rv32, rd32);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            issue8(1'b1, 8'(i), 8'(i));
            issue32(1'b1, 8'(i), 32'(i) << 8, 4'b1111);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                v8 = 1'b1; we8 = 1'b0; a8 = 8'(i + 1);
            end else v8 = 1'b0;
            @(negedge clk);
            total++;
            if (i < 3) begin
                if (rv8 !== 1'b1 || rd8 !== 8'(i + 1))
                    $display("FAIL stream8_%0d: valid=%b rdata=%h, want 1/%h", i, rv8, rd8, 8'(i + 1));
                else passed++;
            end else begin
                if (rv8 !== 1'b0) $display("FAIL stream8_end: valid=%b, want 0", rv8);
                else passed++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                v32 = 1'b1; we32 = 1'b0; a32 = 8'(i + 1);
            end else v32 = 1'b0;
            @(negedge clk);
            total++;
            if (i >= 1 && i <= 3) begin
                if (rv32 !== 1'b1 || rd32 !== (32'(i) << 8))
                    $display("FAIL stream32_%0d: valid=%b rdata=%h, want 1/%h", i, rv32, rd32, 32'(i) << 8);
                else passed++;
            end else begin
                if (rv32 !== 1'b0) $display("FAIL stream32_idle_%0d: valid=%b, want 0", i, rv32);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt, sp;
        issue8(1'b1, 8'h20, 8'h5A);
        issue32(1'b1, 8'h20, 32'h0000_005A, 4'b0001);
        v8 = 1'b1; we8 = 1'b0; a8 = 8'h20;
        v32 = 1'b1; we32 = 1'b0; a32 = 8'h20;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v8 = 1'b0;
        v32 = 1'b0;
        #1;
        total++;
        if ({rv8, rd8, rdy8, done8, rv32, rd32, rdy32, done32} !== 46'h0)
            $display("FAIL rst_async: rv8=%b rd8=%h rdy8=%b done8=%b rv32=%b rd32=%h rdy32=%b done32=%b, want all 0",
                     rv8, rd8, rdy8, done8, rv32, rd32, rdy32, done32);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_wait(cnt, sp);
        total++;
        if (cnt != 256 || sp != 0) $display("FAIL rst_mid_clear: %0d cycles, %0d stray pulses, want 256/0", cnt, sp);
        else passed++;
        issue8(1'b0, 8'h20, 8'h00);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'h00) $display("FAIL rst_mid_rd8: valid=%b rdata=%h, want 1/00", rv8, rd8);
        else passed++;
        issue32(1'b0, 8'h20, 32'h0, 4'b0000);
        @(negedge clk);
        total++;
        if (rv32 !== 1'b1 || rd32 !== 32'h0) $display("FAIL rst_mid_rd32: valid=%b rdata=%h, want 1/00000000", rv32, rd32);
        else passed++;
    endtask

    task automatic test_stall();
        int cnt, sp;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        v8 = 1'b1; we8 = 1'b1; a8 = 8'h33; wd8 = 8'h77; be8 = 1'b1;
        v32 = 1'b1; we32 = 1'b0; a32 = 8'h05;
        rst_n = 1'b1;
        clear_wait(cnt, sp);
        total++;
        if (cnt != 256 || sp != 0) $display("FAIL stall_clear: %0d cycles, %0d stray pulses, want 256/0", cnt, sp);
        else passed++;
        @(negedge clk);
        v8 = 1'b0;
        v32 = 1'b0;
        total++;
        if (rv32 !== 1'b0) $display("FAIL stall_rd_early: valid=%b, want 0", rv32);
        else passed++;
        @(negedge clk);
        total++;
        if (rv32 !== 1'b1 || rd32 !== 32'h0) $display("FAIL stall_rd32: valid=%b rdata=%h, want 1/00000000", rv32, rd32);
        else passed++;
        @(negedge clk);
        total++;
        if (rv32 !== 1'b0) $display("FAIL stall_single: valid=%b, want 0", rv32);
        else passed++;
        issue8(1'b0, 8'h33, 8'h00);
        total++;
        if (rv8 !== 1'b1 || rd8 !== 8'h77) $display("FAIL stall_wr8: valid=%b rdata=%h, want 1/77", rv8, rd8);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
